// File: rtl/dd_pkg.sv
// Shared definitions for the sample read path: widths, burst size and reader FSM states.
package dd_pkg;

   localparam int unsigned SAMPLE_WIDTH    = 10;
   localparam int unsigned HOST_WIDTH      = 16;
   localparam int unsigned FIFO_HALF_LEVEL = 8192;

   typedef enum logic [1:0] {
      StIdle,
      StBurst,
      StEnd
   } state_e;

endpackage

// File: rtl/burst_counter.sv
// Counts pops within one burst and flags the terminal count.
module burst_counter #(
   parameter int unsigned COUNT_WIDTH = 14,
   parameter int unsigned BURST_WORDS = 8192
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   clr_i,
   input  logic                   inc_i,
   output logic [COUNT_WIDTH-1:0] count_o,
   output logic                   last_o
);

   localparam logic [COUNT_WIDTH-1:0] LastCount = COUNT_WIDTH'(BURST_WORDS - 1);

   logic [COUNT_WIDTH-1:0] count_q, count_d;

   // Clear on burst start, otherwise advance once per pop.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i) begin
         count_d = count_q + COUNT_WIDTH'(1);
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // The terminal compare is taken before the increment, so the counter never wraps.
   assign count_o = count_q;
   assign last_o  = (count_q == LastCount);

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains the sample FIFO in fixed-length bursts towards the host write logic.
module fifo_burst_reader
   import dd_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = SAMPLE_WIDTH,
   parameter int unsigned OUT_WIDTH   = HOST_WIDTH,
   parameter int unsigned BURST_WORDS = FIFO_HALF_LEVEL,
   parameter int unsigned COUNT_WIDTH = 14
) (
   input  logic                  outputClock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] fifoData,
   input  logic                  fifoEmpty,
   input  logic                  fifoAlmostEmpty,
   input  logic                  fifoHalfFull,
   input  logic                  fifoFull,
   output logic                  fifoAck,
   input  logic                  hostReady,
   output logic [OUT_WIDTH-1:0]  dataOut,
   output logic                  dataValid,
   output logic                  burstEnd,
   output logic                  overflow
);

   state_e                 state_q, state_d;
   logic [OUT_WIDTH-1:0]   data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   end_q, end_d;
   logic                   overflow_q, overflow_d;
   logic                   pop;
   logic                   cnt_clr;
   logic                   cnt_last;
   logic [COUNT_WIDTH-1:0] cnt_value;

   burst_counter #(
      .COUNT_WIDTH (COUNT_WIDTH),
      .BURST_WORDS (BURST_WORDS)
   ) u_burst_counter (
      .clk_i   (outputClock),
      .rst_i   (reset),
      .clr_i   (cnt_clr),
      .inc_i   (pop),
      .count_o (cnt_value),
      .last_o  (cnt_last)
   );

   // Next state, pop request and registered output values.
   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      valid_d    = 1'b0;
      end_d      = 1'b0;
      pop        = 1'b0;
      cnt_clr    = 1'b0;
      overflow_d = overflow_q | fifoFull;
      unique case (state_q)
         StIdle: begin
            if (fifoHalfFull && hostReady) begin
               state_d = StBurst;
               cnt_clr = 1'b1;
            end
         end
         StBurst: begin
            // Almost-empty absorbs the flag latency; the empty term is only a backstop.
            pop = hostReady && !fifoAlmostEmpty && !fifoEmpty;
            if (pop) begin
               data_d  = {{(OUT_WIDTH - DATA_WIDTH){1'b0}}, fifoData};
               valid_d = 1'b1;
               if (cnt_last) begin
                  state_d = StEnd;
                  end_d   = 1'b1;
               end
            end
         end
         StEnd: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and output registers; reset abandons any burst in flight.
   always_ff @(posedge outputClock) begin
      if (reset) begin
         state_q    <= StIdle;
         data_q     <= '0;
         valid_q    <= 1'b0;
         end_q      <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         end_q      <= end_d;
         overflow_q <= overflow_d;
      end
   end

   assign fifoAck   = pop;
   assign dataOut   = data_q;
   assign dataValid = valid_q;
   assign burstEnd  = end_q;
   assign overflow  = overflow_q;

   // Count value is only needed for the terminal compare inside the counter.
   logic unused_cnt;
   assign unused_cnt = ^cnt_value;

endmodule
